// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces two coin sensors,
// buffers accepted coins in a 4-entry FIFO and presents them one at a time
// to the vending machine, with an idle gap cycle between coins.

// Per-channel debouncer: a coin is accepted once the synchronized level
// has stayed high for DEBOUNCE cycles, and must stay low for DEBOUNCE
// cycles before the next insertion can be recognised.
module coin_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic accepted
);

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      QUAL_HI = 2'd1,
      HIGH    = 2'd2,
      QUAL_LO = 2'd3
   } deb_state_t;

   localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE);

   deb_state_t state, state_next;
   logic [3:0] cnt, cnt_next;
   logic [3:0] cnt_inc;

   assign cnt_inc = cnt + 4'd1;

   // State and counter registers, cleared by the synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= LOW;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic; the acceptance pulse fires on the transition into HIGH
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accepted   = 1'b0;
      case (state)
         LOW: begin
            if (din) begin
               state_next = QUAL_HI;
               cnt_next   = 4'd1;
            end
         end
         QUAL_HI: begin
            if (!din) begin
               state_next = LOW;
               cnt_next   = 4'd0;
            end else if (cnt_inc == DEB_LIMIT) begin
               state_next = HIGH;
               cnt_next   = 4'd0;
               accepted   = 1'b1;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         HIGH: begin
            if (!din) begin
               state_next = QUAL_LO;
               cnt_next   = 4'd1;
            end
         end
         QUAL_LO: begin
            if (din) begin
               state_next = HIGH;
               cnt_next   = 4'd0;
            end else if (cnt_inc == DEB_LIMIT) begin
               state_next = LOW;
               cnt_next   = 4'd0;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = 4'd0;
         end
      endcase
   end

endmodule

// Top level: two sensor channels feeding a small coin FIFO.
module coin_acceptor #(
   parameter int DEBOUNCE = 4,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   input  logic       hold,
   output logic [1:0] coin,
   output logic       reject,
   output logic [2:0] level,
   output logic       full
);

   localparam logic [2:0] FULL_LEVEL = 3'(DEPTH);

   logic [1:0] sync5, sync10;
   logic       acc5, acc10;
   logic       both, single;
   logic [1:0] code;
   logic       pop, push, reject_next;
   logic       gap;
   logic [1:0] wr_ptr, rd_ptr;
   logic [1:0] mem [DEPTH];

   // Two-flop synchronizers; the raw sensors go nowhere else
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync5  <= 2'b00;
         sync10 <= 2'b00;
      end else begin
         sync5  <= {sync5[0], coin5_raw};
         sync10 <= {sync10[0], coin10_raw};
      end
   end

   coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb5 (
      .clk      (clk),
      .rst      (rst),
      .din      (sync5[1]),
      .accepted (acc5)
   );

   coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb10 (
      .clk      (clk),
      .rst      (rst),
      .din      (sync10[1]),
      .accepted (acc10)
   );

   assign full = (level == FULL_LEVEL);

   // Arbitration: simultaneous coins are ambiguous and go back to the user;
   // a full FIFO can still take a coin when an entry leaves in the same cycle
   always_comb begin
      both        = acc5 & acc10;
      single      = acc5 ^ acc10;
      code        = acc5 ? 2'b01 : 2'b10;
      pop         = (level != 3'd0) && !hold && !gap;
      push        = single && (!full || pop);
      reject_next = both || (single && full && !pop);
   end

   // FIFO storage; contents need no reset because level gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= code;
      end
   end

   // FIFO pointers, occupancy, registered coin output and the gap cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         level  <= 3'd0;
         gap    <= 1'b0;
         coin   <= 2'b00;
         reject <= 1'b0;
      end else begin
         reject <= reject_next;
         gap    <= pop;
         coin   <= pop ? mem[rd_ptr] : 2'b00;
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   level <= level + 3'd1;
            2'b01:   level <= level - 3'd1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a per-cycle vector table for the
// basic latency and glitch cases, plus directed FIFO / reset sequences.
`timescale 1ns/1ps
module tb_coin_acceptor;

   typedef struct {
      logic       rst;
      logic       c5;
      logic       c10;
      logic       hold;
      logic [1:0] exp_coin;
      logic       exp_reject;
      logic [2:0] exp_level;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       coin5_raw;
   logic       coin10_raw;
   logic       hold;
   logic [1:0] coin;
   logic       reject;
   logic [2:0] level;
   logic       full;

   int   errors;
   int   checks;
   int   nvec;
   vec_t vecs [40];
   logic hold_q;

   logic [1:0] drain_seq [8] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
   logic [1:0] bypass_seq [9] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

   coin_acceptor #(.DEBOUNCE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .coin5_raw  (coin5_raw),
      .coin10_raw (coin10_raw),
      .hold       (hold),
      .coin       (coin),
      .reject     (reject),
      .level      (level),
      .full       (full)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs on the falling edge, then sample just after the rising edge
   task automatic applyStimulus(input logic r, input logic c5, input logic c10, input logic h);
      @(negedge clk);
      rst        = r;
      coin5_raw  = c5;
      coin10_raw = c10;
      hold       = h;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic r, input logic c5, input logic c10, input logic h,
                         input logic [1:0] ec, input logic er, input logic [2:0] el);
      vecs[nvec].rst        = r;
      vecs[nvec].c5         = c5;
      vecs[nvec].c10        = c10;
      vecs[nvec].hold       = h;
      vecs[nvec].exp_coin   = ec;
      vecs[nvec].exp_reject = er;
      vecs[nvec].exp_level  = el;
      nvec++;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, hold_q);
      applyStimulus(1'b0, 1'b0, 1'b0, hold_q);
   endtask

   // One insertion: sensor high 6 cycles, then low long enough to requalify LOW
   task automatic insertCoin(input logic is_ten, output int rej_cycles, output int coin_cycles);
      rej_cycles  = 0;
      coin_cycles = 0;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(1'b1, (k < 6) && !is_ten, (k < 6) && is_ten, hold_q);
         if (reject) rej_cycles++;
         if (coin != 2'b00) coin_cycles++;
      end
   endtask

   initial begin
      int rej_n;
      int coin_n;
      int rej_total;
      int coin_total;

      errors     = 0;
      checks     = 0;
      nvec       = 0;
      hold_q     = 1'b0;
      rst        = 1'b0;
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      hold       = 1'b0;

      // Single 5-unit coin: pushed on edge 6, presented on edge 7 for one cycle
      addVec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      for (int k = 1; k <= 10; k++) begin
         addVec(1'b1, 1'b1, 1'b0, 1'b0,
                (k == 7) ? 2'd1 : 2'd0, 1'b0,
                (k == 6) ? 3'd1 : 3'd0);
      end
      for (int k = 11; k <= 16; k++) begin
         addVec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      end
      // 10-unit glitches of 3 cycles separated by one low cycle: nothing accepted
      addVec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      for (int k = 0; k < 14; k++) begin
         addVec(1'b1, 1'b0, (k < 3) || (k >= 4 && k < 7), 1'b0, 2'd0, 1'b0, 3'd0);
      end

      for (int i = 0; i < nvec; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].c5, vecs[i].c10, vecs[i].hold);
         checkOutput($sformatf("vec%0d coin", i), int'(coin), int'(vecs[i].exp_coin));
         checkOutput($sformatf("vec%0d reject", i), int'(reject), int'(vecs[i].exp_reject));
         checkOutput($sformatf("vec%0d level", i), int'(level), int'(vecs[i].exp_level));
         if (i == 0) begin
            checkOutput("reset full", int'(full), 0);
         end
      end

      // Five coins while held: fifth is rejected, then the FIFO drains in order
      $display("[TB] fifo fill and drain");
      hold_q = 1'b1;
      doReset();
      for (int n = 0; n < 5; n++) begin
         insertCoin(n[0], rej_n, coin_n);
         checkOutput($sformatf("fill%0d reject cycles", n), rej_n, (n == 4) ? 1 : 0);
         checkOutput($sformatf("fill%0d coin cycles", n), coin_n, 0);
         checkOutput($sformatf("fill%0d level", n), int'(level), (n < 4) ? n + 1 : 4);
      end
      checkOutput("fill full", int'(full), 1);
      hold_q = 1'b0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, hold_q);
         checkOutput($sformatf("drain%0d coin", k), int'(coin), int'(drain_seq[k]));
      end
      checkOutput("drain level", int'(level), 0);
      checkOutput("drain full", int'(full), 0);

      // Both sensors together: one reject pulse, nothing buffered or presented
      $display("[TB] simultaneous coins");
      doReset();
      rej_total  = 0;
      coin_total = 0;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(1'b1, k < 6, k < 6, 1'b0);
         if (reject) rej_total++;
         if (coin != 2'b00) coin_total++;
         if (level != 3'd0) coin_total++;
      end
      checkOutput("dual reject cycles", rej_total, 1);
      checkOutput("dual coin or level activity", coin_total, 0);

      // Reset while three coins are buffered discards them silently
      $display("[TB] reset with buffered coins");
      hold_q = 1'b1;
      doReset();
      for (int n = 0; n < 3; n++) begin
         insertCoin(1'b0, rej_n, coin_n);
      end
      checkOutput("prereset level", int'(level), 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("midreset level", int'(level), 0);
      checkOutput("midreset full", int'(full), 0);
      checkOutput("midreset coin", int'(coin), 0);
      checkOutput("midreset reject", int'(reject), 0);
      hold_q     = 1'b0;
      coin_total = 0;
      rej_total  = 0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, hold_q);
         if (coin != 2'b00) coin_total++;
         if (reject) rej_total++;
      end
      checkOutput("postreset coin cycles", coin_total, 0);
      checkOutput("postreset reject cycles", rej_total, 0);

      // Full FIFO with a new coin landing on the same edge as the first pop
      $display("[TB] full fifo with coincident pop");
      hold_q = 1'b1;
      doReset();
      for (int n = 0; n < 4; n++) begin
         insertCoin(n[0], rej_n, coin_n);
      end
      checkOutput("prebypass level", int'(level), 4);
      checkOutput("prebypass full", int'(full), 1);
      rej_total = 0;
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, (k < 6));
         if (reject) rej_total++;
      end
      checkOutput("bypass first coin", int'(coin), 1);
      checkOutput("bypass level", int'(level), 4);
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, (k == 0), 1'b0, 1'b0);
         if (reject) rej_total++;
         checkOutput($sformatf("bypass%0d coin", k), int'(coin), int'(bypass_seq[k]));
      end
      checkOutput("bypass reject cycles", rej_total, 0);
      checkOutput("bypass final level", int'(level), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
